// File: rtl/game_scheduler.sv
// Per-frame game sequencer: game-phase FSM, move strobe with speed-dependent step,
// BCD score, high score and speed level.
module game_scheduler #(
    parameter int unsigned SCORE_DIV   = 6,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned MAX_LEVEL   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick_60hz,
    input  logic        i_game_start,
    input  logic        i_game_over,
    input  logic        i_crash,
    output logic        o_move_en,
    output logic [2:0]  o_step,
    output logic [1:0]  o_speed_level,
    output logic [15:0] o_score,
    output logic [15:0] o_hiscore,
    output logic        o_running,
    output logic        o_frozen
);

    localparam int unsigned DIV_W  = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int unsigned HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
    localparam logic [1:0]        LVL_MAX   = 2'(MAX_LEVEL);

    typedef enum logic [1:0] {StIdle, StRun, StCrash, StOver} state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [HOLD_W-1:0]   r_hold;
    logic [15:0]         r_score;
    logic [15:0]         r_hiscore;
    logic [1:0]          r_level;
    logic [2:0]          r_step;
    logic                r_move_en;
    logic                r_running;
    logic                r_frozen;

    logic [15:0]         w_score_inc;
    logic                w_hund_carry;
    logic [1:0]          w_level_inc;
    logic [2:0]          w_step_inc;

    // BCD increment saturating at 9999; flags a carry into the hundreds digit.
    always_comb begin
        w_score_inc  = r_score;
        w_hund_carry = 1'b0;
        if (r_score != 16'h9999) begin
            if (r_score[3:0] != 4'd9) begin
                w_score_inc[3:0] = r_score[3:0] + 4'd1;
            end else begin
                w_score_inc[3:0] = 4'd0;
                if (r_score[7:4] != 4'd9) begin
                    w_score_inc[7:4] = r_score[7:4] + 4'd1;
                end else begin
                    w_score_inc[7:4] = 4'd0;
                    w_hund_carry     = 1'b1;
                    if (r_score[11:8] != 4'd9) begin
                        w_score_inc[11:8] = r_score[11:8] + 4'd1;
                    end else begin
                        w_score_inc[11:8]  = 4'd0;
                        w_score_inc[15:12] = r_score[15:12] + 4'd1;
                    end
                end
            end
        end
    end

    assign w_level_inc = (w_hund_carry && (r_level != LVL_MAX)) ? r_level + 2'd1 : r_level;
    assign w_step_inc  = {1'b0, w_level_inc} + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_div     <= '0;
            r_hold    <= '0;
            r_score   <= 16'h0000;
            r_hiscore <= 16'h0000;
            r_level   <= 2'd0;
            r_step    <= 3'd1;
            r_move_en <= 1'b0;
            r_running <= 1'b0;
            r_frozen  <= 1'b0;
        end else begin
            r_move_en <= 1'b0;
            unique case (r_state)
                StIdle, StOver: begin
                    if (i_game_start) begin
                        r_state   <= StRun;
                        r_running <= 1'b1;
                        r_score   <= 16'h0000;
                        r_div     <= '0;
                        r_level   <= 2'd0;
                        r_step    <= 3'd1;
                    end
                end
                StRun: begin
                    // A crash or game-over beats a coincident tick.
                    if (i_crash || i_game_over) begin
                        r_state   <= StCrash;
                        r_hold    <= HOLD_INIT;
                        r_running <= 1'b0;
                        r_frozen  <= 1'b1;
                    end else if (i_tick_60hz) begin
                        r_move_en <= 1'b1;
                        if (r_div == DIV_LAST) begin
                            r_div   <= '0;
                            r_score <= w_score_inc;
                            r_level <= w_level_inc;
                            r_step  <= w_step_inc;
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                end
                StCrash: begin
                    if (i_tick_60hz) begin
                        if (r_hold <= HOLD_W'(1)) begin
                            r_hold   <= '0;
                            r_state  <= StOver;
                            r_frozen <= 1'b0;
                            if (r_score > r_hiscore) begin
                                r_hiscore <= r_score;
                            end
                        end else begin
                            r_hold <= r_hold - HOLD_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign o_move_en     = r_move_en;
    assign o_step        = r_step;
    assign o_speed_level = r_level;
    assign o_score       = r_score;
    assign o_hiscore     = r_hiscore;
    assign o_running     = r_running;
    assign o_frozen      = r_frozen;

endmodule

// File: tb/tb_game_scheduler.sv
// Self-checking bench for game_scheduler: vector table for phase/score checks, a strobe
// scoreboard fed by a small integer model, and a fast-divider instance for saturation.
module tb_game_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_tick, i_start, i_gover, i_crash;
    logic        o_move_en, o_running, o_frozen;
    logic [2:0]  o_step;
    logic [1:0]  o_lvl;
    logic [15:0] o_score, o_hi;

    logic        f_tick, f_start;
    logic        f_move_en, f_running, f_frozen;
    logic [2:0]  f_step;
    logic [1:0]  f_lvl;
    logic [15:0] f_score, f_hi;

    always #5 clk = ~clk;

    game_scheduler u_dut (
        .clk(clk), .rst(rst), .i_tick_60hz(i_tick), .i_game_start(i_start),
        .i_game_over(i_gover), .i_crash(i_crash), .o_move_en(o_move_en), .o_step(o_step),
        .o_speed_level(o_lvl), .o_score(o_score), .o_hiscore(o_hi), .o_running(o_running),
        .o_frozen(o_frozen)
    );

    game_scheduler #(.SCORE_DIV(1), .HOLD_FRAMES(2), .MAX_LEVEL(3)) u_fast (
        .clk(clk), .rst(rst), .i_tick_60hz(f_tick), .i_game_start(f_start),
        .i_game_over(1'b0), .i_crash(1'b0), .o_move_en(f_move_en), .o_step(f_step),
        .o_speed_level(f_lvl), .o_score(f_score), .o_hiscore(f_hi), .o_running(f_running),
        .o_frozen(f_frozen)
    );

    typedef struct {
        logic        start, gover, crash, ctick;
        int          ticks;
        logic        run, frz;
        logic [15:0] score, hi;
        logic [1:0]  lvl;
    } vec_t;

    typedef struct {
        logic [15:0] score;
        logic [2:0]  step;
    } sb_t;

    vec_t vecs[16];
    sb_t  sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_st, m_score, m_div, m_hold;
    logic m_mv;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Integer reference for the phase and per-strobe score; 0 idle, 1 run, 2 crash, 3 over.
    task automatic model(input logic s, input logic g, input logic c, input logic t);
        int lvl;
        sb_t e;
        m_mv = 1'b0;
        case (m_st)
            0, 3: if (s) begin m_st = 1; m_score = 0; m_div = 0; end
            1: begin
                if (c || g) begin
                    m_st = 2; m_hold = 30;
                end else if (t) begin
                    m_div++;
                    if (m_div == 6) begin
                        m_div = 0;
                        if (m_score < 9999) m_score++;
                    end
                    lvl = (m_score / 100 > 3) ? 3 : m_score / 100;
                    m_mv = 1'b1;
                    e.score = to_bcd(m_score);
                    e.step = 3'(lvl + 1);
                    sb_q.push_back(e);
                end
            end
            2: if (t) begin
                m_hold--;
                if (m_hold == 0) m_st = 3;
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic s, input logic g, input logic c, input logic t);
        sb_t e;
        i_start = s; i_gover = g; i_crash = c; i_tick = t;
        model(s, g, c, t);
        @(posedge clk);
        @(negedge clk);
        i_start = 1'b0; i_gover = 1'b0; i_crash = 1'b0; i_tick = 1'b0;
        chk("move_en", 16'(o_move_en), 16'(m_mv));
        if (o_move_en) begin
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_strobe: got strobe expected none at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("sb_score", o_score, e.score);
                chk("sb_step", 16'(o_step), 16'(e.step));
            end
        end
    endtask

    task automatic tick();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_score"}, o_score, 16'h0000);
        chk({tag, "_hi"}, o_hi, 16'h0000);
        chk({tag, "_lvl"}, 16'(o_lvl), 16'd0);
        chk({tag, "_step"}, 16'(o_step), 16'd1);
        chk({tag, "_move"}, 16'(o_move_en), 16'd0);
        chk({tag, "_run"}, 16'(o_running), 16'd0);
        chk({tag, "_frz"}, 16'(o_frozen), 16'd0);
    endtask

    initial begin
        int cnt;
        //        start  gover  crash  ctick  ticks run   frz   score     hi        lvl
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2,   1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 60,  1'b1, 1'b0, 16'h0010, 16'h0000, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 192, 1'b1, 1'b0, 16'h0042, 16'h0000, 2'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 0,   1'b0, 1'b1, 16'h0042, 16'h0000, 2'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 29,  1'b0, 1'b1, 16'h0042, 16'h0000, 2'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1,   1'b0, 1'b0, 16'h0042, 16'h0042, 2'd0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 16'h0000, 16'h0042, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 102, 1'b1, 1'b0, 16'h0017, 16'h0042, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b1, 16'h0017, 16'h0042, 2'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b1, 16'h0017, 16'h0042, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 30,  1'b0, 1'b0, 16'h0017, 16'h0042, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 0,   1'b1, 1'b0, 16'h0000, 16'h0042, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 600, 1'b1, 1'b0, 16'h0100, 16'h0042, 2'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b1, 16'h0100, 16'h0042, 2'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 15,  1'b0, 1'b1, 16'h0100, 16'h0042, 2'd1};

        rst = 1'b1; i_tick = 1'b0; i_start = 1'b0; i_gover = 1'b0; i_crash = 1'b0;
        f_tick = 1'b0; f_start = 1'b0;
        m_st = 0; m_score = 0; m_div = 0; m_hold = 0; m_mv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset("rst");
        chk("f_rst_score", f_score, 16'h0000);

        // Saturation on a divide-by-1 instance with back-to-back ticks.
        f_start = 1'b1;
        @(posedge clk); @(negedge clk);
        f_start = 1'b0;
        f_tick = 1'b1;
        repeat (9999) @(posedge clk);
        @(negedge clk);
        f_tick = 1'b0;
        @(negedge clk);
        chk("sat_score", f_score, 16'h9999);
        chk("sat_lvl", 16'(f_lvl), 16'd3);
        chk("sat_step", 16'(f_step), 16'd4);
        cnt = 0;
        repeat (12) begin
            f_tick = 1'b1;
            @(posedge clk); @(negedge clk);
            f_tick = 1'b0;
            if (f_move_en) cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("sat_strobes", 16'(cnt), 16'd12);
        chk("sat_hold", f_score, 16'h9999);
        chk("sat_run", 16'(f_running), 16'd1);

        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].start, vecs[i].gover, vecs[i].crash, vecs[i].ctick);
            for (int k = 0; k < vecs[i].ticks; k++) tick();
            chk($sformatf("v%0d_run", i), 16'(o_running), 16'(vecs[i].run));
            chk($sformatf("v%0d_frz", i), 16'(o_frozen), 16'(vecs[i].frz));
            chk($sformatf("v%0d_score", i), o_score, vecs[i].score);
            chk($sformatf("v%0d_hi", i), o_hi, vecs[i].hi);
            chk($sformatf("v%0d_lvl", i), 16'(o_lvl), 16'(vecs[i].lvl));
            chk($sformatf("v%0d_step", i), 16'(o_step), 16'(vecs[i].lvl) + 16'd1);
        end

        // Reset mid-crash (hold counter at 15) with competing start and tick.
        rst = 1'b1; i_tick = 1'b1; i_start = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; i_tick = 1'b0; i_start = 1'b0;
        m_st = 0; m_score = 0; m_div = 0; m_hold = 0;
        sb_q.delete();
        chk_reset("midrst");

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk("post_score", o_score, 16'h0001);
        chk("post_hi", o_hi, 16'h0000);
        chk("sb_left", 16'(sb_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
